// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory ready handshake and traps illegal opcodes or memory timeouts into FAULT.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TIMEOUT_EN  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       fault,
   output logic [3:0] state
);

   localparam logic [3:0] S_RESET  = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_REX    = 4'd7;
   localparam logic [3:0] S_RWB    = 4'd8;
   localparam logic [3:0] S_IEX    = 4'd9;
   localparam logic [3:0] S_IWB    = 4'd10;
   localparam logic [3:0] S_BR     = 4'd11;
   localparam logic [3:0] S_JMP    = 4'd12;
   localparam logic [3:0] S_JAL    = 4'd13;
   localparam logic [3:0] S_JR     = 4'd14;
   localparam logic [3:0] S_FAULT  = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_SLT  = 3'd2;
   localparam logic [2:0] ALU_XOR  = 3'd3;

   localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

   logic [3:0]       cur;
   logic [3:0]       nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_phase;
   logic             timeout;

   assign state     = cur;
   assign mem_phase = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
   // A ready on the last allowed cycle completes the access, so timeout requires !mem_ready.
   assign timeout   = mem_phase && !mem_ready && (TIMEOUT_EN != 0) &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur      <= S_RESET;
         wait_cnt <= '0;
      end else begin
         cur <= nxt;
         if (nxt != cur)
            wait_cnt <= '0;
         else if (mem_phase && !mem_ready && (wait_cnt != {CNT_W{1'b1}}))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      nxt = cur;
      case (cur)
         S_RESET:  nxt = S_FETCH;
         S_FETCH:  nxt = mem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     nxt = S_MEMADR;
               OP_ADDI, OP_XORI: nxt = S_IEX;
               OP_BEQ, OP_BNE:   nxt = S_BR;
               OP_J:             nxt = S_JMP;
               OP_JAL:           nxt = S_JAL;
               OP_RTYPE: begin
                  case (funct)
                     FN_ADD, FN_SUB, FN_SLT: nxt = S_REX;
                     FN_JR:                  nxt = S_JR;
                     default:                nxt = S_FAULT;
                  endcase
               end
               default:          nxt = S_FAULT;
            endcase
         end
         S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nxt = mem_ready ? S_MEMWB : (timeout ? S_FAULT : S_MEMRD);
         S_MEMWR:  nxt = mem_ready ? S_FETCH : (timeout ? S_FAULT : S_MEMWR);
         S_REX:    nxt = S_RWB;
         S_IEX:    nxt = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BR, S_JMP, S_JAL, S_JR: nxt = S_FETCH;
         S_FAULT:  nxt = S_FAULT;
         default:  nxt = S_FAULT;
      endcase
   end

   always_comb begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_ADD;
      pc_src     = 2'd0;
      instr_done = 1'b0;
      fault      = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         S_DECODE: alu_src_b = 2'd3;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            mem_to_reg = 2'd1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
         end
         S_REX: begin
            alu_src_a = 1'b1;
            alu_op    = (funct == FN_SUB) ? ALU_SUB : ((funct == FN_SLT) ? ALU_SLT : ALU_ADD);
         end
         S_RWB: begin
            reg_we     = 1'b1;
            reg_dst    = 2'd1;
            instr_done = 1'b1;
         end
         S_IEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
         end
         S_IWB: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
         end
         S_BR: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = 2'd1;
            pc_we      = (opcode == OP_BNE) ? !zero : zero;
            instr_done = 1'b1;
         end
         S_JMP: begin
            pc_src     = 2'd2;
            pc_we      = 1'b1;
            instr_done = 1'b1;
         end
         // Regfile captures the PC that FETCH already advanced to PC+4.
         S_JAL: begin
            pc_src     = 2'd2;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            instr_done = 1'b1;
         end
         S_JR: begin
            pc_src     = 2'd3;
            pc_we      = 1'b1;
            instr_done = 1'b1;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed reset/fault/timeout steps plus random instruction
// streams compared against an instruction-level model of latency and control outputs.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_we, ir_we, mem_req, mem_we, iord, reg_we;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
   logic       alu_src_a, instr_done, fault;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic [19:0] outs;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   multicycle_control #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req),
      .mem_we(mem_we), .iord(iord), .reg_we(reg_we), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done), .fault(fault),
      .state(state)
   );

   always #5 clk = ~clk;

   assign outs = {pc_we, ir_we, mem_req, mem_we, iord, reg_we, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, instr_done, fault};

   // Instruction table: 0 LW, 1 SW, 2 ADD, 3 SUB, 4 SLT, 5 ADDI, 6 XORI, 7 BEQ, 8 BNE, 9 J, 10 JAL, 11 JR
   logic [5:0] tbl_op [12] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E,
                               6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
   logic [5:0] tbl_fn [12] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h2A, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_outs", 32'(outs), 0);
      chk("rst_state", 32'(state), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_to_fetch_memreq", 32'(mem_req), 1);
   endtask

   // Runs one instruction starting in FETCH; the responder inserts wf wait cycles on the
   // fetch and wm on the data access, and ready outside an access is random noise.
   task automatic run_instr(input int idx, input logic z, input int wf, input int wm);
      int left, cyc, mreq, lat_e, mreq_e, wm_e;
      logic seen;
      logic [3:0] fetch_v;
      logic [5:0] exec_v, exec_e;
      logic [8:0] done_v, done_e;
      opcode = tbl_op[idx];
      funct  = (tbl_op[idx] == 6'h00) ? tbl_fn[idx] : 6'($urandom_range(0, 63));
      zero   = z;
      left = wf; cyc = 0; mreq = 0; seen = 1'b0;
      fetch_v = '0; exec_v = '0; done_v = '0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         if (mem_req) begin
            if (left > 0) begin mem_ready = 1'b0; left--; end
            else begin mem_ready = 1'b1; left = wm; end
         end else mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (mem_req) mreq++;
         if (cyc == wf) fetch_v = {ir_we, pc_we, iord, alu_src_b[0]};
         if (cyc == wf + 2) exec_v = {alu_src_a, alu_src_b, alu_op};
         if (instr_done) begin seen = 1'b1; done_v = {reg_we, reg_dst, mem_to_reg, pc_we, pc_src, mem_we}; end
         cyc++;
      end
      wm_e = (idx <= 1) ? wm : 0;
      mreq_e = 1 + wf + ((idx <= 1) ? 1 + wm : 0);
      case (idx)
         0:  begin lat_e = 5; exec_e = {1'b1, 2'd2, 3'd0}; done_e = {1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0}; end
         1:  begin lat_e = 4; exec_e = {1'b1, 2'd2, 3'd0}; done_e = {1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1}; end
         2:  begin lat_e = 4; exec_e = {1'b1, 2'd0, 3'd0}; done_e = {1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0}; end
         3:  begin lat_e = 4; exec_e = {1'b1, 2'd0, 3'd1}; done_e = {1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0}; end
         4:  begin lat_e = 4; exec_e = {1'b1, 2'd0, 3'd2}; done_e = {1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0}; end
         5:  begin lat_e = 4; exec_e = {1'b1, 2'd2, 3'd0}; done_e = {1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0}; end
         6:  begin lat_e = 4; exec_e = {1'b1, 2'd2, 3'd3}; done_e = {1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0}; end
         7:  begin lat_e = 3; exec_e = {1'b1, 2'd0, 3'd1}; done_e = {1'b0, 2'd0, 2'd0, z, 2'd1, 1'b0}; end
         8:  begin lat_e = 3; exec_e = {1'b1, 2'd0, 3'd1}; done_e = {1'b0, 2'd0, 2'd0, !z, 2'd1, 1'b0}; end
         9:  begin lat_e = 3; exec_e = '0; done_e = {1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0}; end
         10: begin lat_e = 3; exec_e = '0; done_e = {1'b1, 2'd2, 2'd2, 1'b1, 2'd2, 1'b0}; end
         default: begin lat_e = 3; exec_e = '0; done_e = {1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0}; end
      endcase
      lat_e = lat_e + wf + wm_e;
      chk($sformatf("i%0d_done_seen", idx), 32'(seen), 1);
      chk($sformatf("i%0d_latency", idx), 32'(cyc), 32'(lat_e));
      chk($sformatf("i%0d_memreq_cycles", idx), 32'(mreq), 32'(mreq_e));
      chk($sformatf("i%0d_fetch_ctl", idx), 32'(fetch_v), 32'(4'b1101));
      chk($sformatf("i%0d_exec_ctl", idx), 32'(exec_v), 32'(exec_e));
      chk($sformatf("i%0d_done_ctl", idx), 32'(done_v), 32'(done_e));
   endtask

   task automatic fault_after_decode(input logic [5:0] op, input logic [5:0] fn, input string tag);
      int bad;
      opcode = op; funct = fn;
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); #1;
      chk({tag, "_enter"}, 32'(outs), 1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         opcode = 6'($urandom_range(0, 63));
         #1;
         if (outs !== 20'h1) bad++;
      end
      chk({tag, "_sticky_bad_cycles"}, 32'(bad), 0);
      do_reset();
   endtask

   initial begin
      int idx, wf, wm;
      // Power-on reset
      repeat (2) @(negedge clk);
      chk("por_outs", 32'(outs), 0);
      chk("por_state", 32'(state), 0);
      reset_n = 1'b1;
      #1;
      chk("por_release_still_reset", 32'(state), 0);
      @(posedge clk); #1;
      chk("por_fetch_memreq", 32'(mem_req), 1);

      // Directed instructions, always ready
      run_instr(2, 1'b0, 0, 0);
      run_instr(0, 1'b0, 0, 0);
      run_instr(1, 1'b0, 0, 0);
      run_instr(7, 1'b1, 0, 0);
      run_instr(8, 1'b1, 0, 0);
      run_instr(10, 1'b0, 0, 0);
      run_instr(11, 1'b0, 0, 0);

      // Reset asserted mid-MEMRD
      opcode = 6'h23; funct = 6'h00;
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("memrd_reached", 32'({mem_req, iord, mem_we}), 32'(3'b110));
      #1 reset_n = 1'b0;
      #1;
      chk("midrd_rst_outs", 32'(outs), 0);
      chk("midrd_rst_state", 32'(state), 0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      chk("midrd_release_fetch", 32'({mem_req, iord}), 32'(2'b10));

      // Illegal instructions
      fault_after_decode(6'h3F, 6'h20, "op3f");
      fault_after_decode(6'h00, 6'h01, "fn01");

      // Fetch timeout with MEM_TIMEOUT=4
      opcode = 6'h08;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ready = 1'b0; #1;
         chk($sformatf("to_wait%0d", i), 32'({fault, mem_req}), 32'(2'b01));
      end
      @(negedge clk); #1;
      chk("to_fault", 32'(outs), 1);
      do_reset();

      // Ready on the 4th fetch cycle completes normally
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mem_ready = (i == 3); #1;
      end
      @(negedge clk); mem_ready = 1'b0; #1;
      chk("late_ready_decode", 32'({fault, alu_src_b, mem_req}), 32'(4'b0110));
      do_reset();

      // Random instruction stream with random wait states
      for (int n = 0; n < 60; n++) begin
         idx = int'($urandom_range(0, 11));
         wf  = int'($urandom_range(0, 3));
         wm  = int'($urandom_range(0, 3));
         run_instr(idx, 1'($urandom_range(0, 1)), wf, wm);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed %0d checks expected completion", checks);
      $fatal(1, "watchdog");
   end

endmodule
